// File: rtl/alu_md_pkg.sv
// Shared types and constants for the RV32I/M ALU controller.
// Holds the ALU operation encoding, the M-engine state and the Funct7/Funct3 constants.
package alu_md_pkg;

   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_SUB  = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_SLL  = 4'b0101,
      OP_SRL  = 4'b0110,
      OP_SRA  = 4'b0111,
      OP_SLT  = 4'b1000,
      OP_SLTU = 4'b1001,
      OP_BEQ  = 4'b1010,
      OP_BNE  = 4'b1011,
      OP_BLT  = 4'b1100,
      OP_BGE  = 4'b1101,
      OP_BLTU = 4'b1110,
      OP_BGEU = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } md_state_e;

   localparam logic [1:0] ALUOP_MEM = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_RI  = 2'b10;
   localparam logic [1:0] ALUOP_JL  = 2'b11;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/Funct3/Funct7/Jalr -> ALU Operation decode for base RV32I.
// M-extension instructions map to ADD so the ALU output is harmless while the M engine runs.
import alu_md_pkg::*;

module alu_op_decode (
   input  logic [1:0] aluop_i,
   input  logic       is_rtype_i,
   input  logic [6:0] funct7_i,
   input  logic [2:0] funct3_i,
   input  logic       jalr_i,
   output alu_op_e    op_o
);

   always_comb begin
      op_o = OP_ADD;
      case (aluop_i)
         ALUOP_BR: begin
            case (funct3_i)
               3'b000:  op_o = OP_BEQ;
               3'b001:  op_o = OP_BNE;
               3'b100:  op_o = OP_BLT;
               3'b101:  op_o = OP_BGE;
               3'b110:  op_o = OP_BLTU;
               3'b111:  op_o = OP_BGEU;
               default: op_o = OP_ADD;
            endcase
         end
         ALUOP_RI: begin
            if (jalr_i || (is_rtype_i && funct7_i == F7_MULDIV)) begin
               op_o = OP_ADD;
            end else begin
               case (funct3_i)
                  // SUB only exists as an R-type; ADDI's imm[11:5] must not turn it into SUB
                  3'b000:  op_o = (is_rtype_i && funct7_i == F7_ALT) ? OP_SUB : OP_ADD;
                  3'b001:  op_o = OP_SLL;
                  3'b010:  op_o = OP_SLT;
                  3'b011:  op_o = OP_SLTU;
                  3'b100:  op_o = OP_XOR;
                  3'b101:  op_o = (funct7_i == F7_ALT) ? OP_SRA : OP_SRL;
                  3'b110:  op_o = OP_OR;
                  default: op_o = OP_AND;
               endcase
            end
         end
         default: op_o = OP_ADD;
      endcase
   end

endmodule

// File: rtl/alu_controller_md.sv
// ALU controller with an iterative RV32M engine (shift-add multiply, restoring divide).
// Define EARLY_OUT_EN to finish divide-by-zero, signed overflow and multiply-by-zero in two cycles.
import alu_md_pkg::*;

module alu_controller_md #(
   parameter int XLEN = 32,
   parameter int OP_W = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   input  logic            kill,
   input  logic [1:0]      ALUOp,
   input  logic            IsRType,
   input  logic [6:0]      Funct7,
   input  logic [2:0]      Funct3,
   input  logic            Jalr,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic [OP_W-1:0] Operation,
   output logic            md_stall,
   output logic            md_valid,
   output logic [XLEN-1:0] md_result
);

   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

   alu_op_e dec_op;

   alu_op_decode u_dec (
      .aluop_i    (ALUOp),
      .is_rtype_i (IsRType),
      .funct7_i   (Funct7),
      .funct3_i   (Funct3),
      .jalr_i     (Jalr),
      .op_o       (dec_op)
   );

   assign Operation = OP_W'(dec_op);

   md_state_e         state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        f3_q;
   logic [XLEN-1:0]   a_q, b_q, dvd_q, md_result_q;
   logic [2*XLEN-1:0] acc_q;
   logic              neg_q, dz_q, ovf_q, md_valid_q;

   // Result for divide-by-zero and signed overflow, which bypass the iteration result
   function automatic logic [XLEN-1:0] spec_res(input logic is_rem, input logic dz,
                                                input logic [XLEN-1:0] dvd);
      if (dz) return is_rem ? dvd : {XLEN{1'b1}};
      return is_rem ? {XLEN{1'b0}} : MIN_V;
   endfunction

   logic            is_m, accept, in_div, sa, sb, a_neg, b_neg, neg_in, dz_in, ovf_in;
   logic [XLEN-1:0] a_abs, b_abs;

   always_comb begin
      is_m   = req_valid && ALUOp == ALUOP_RI && IsRType && Funct7 == F7_MULDIV;
      accept = is_m && state_q == S_IDLE && !kill && !reset;
      in_div = Funct3[2];
      sa     = in_div ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
      sb     = in_div ? ~Funct3[0] : ~Funct3[1];
      a_neg  = sa & op_a[XLEN-1];
      b_neg  = sb & op_b[XLEN-1];
      a_abs  = a_neg ? -op_a : op_a;
      b_abs  = b_neg ? -op_b : op_b;
      // remainder takes the dividend's sign; everything else the product of signs
      neg_in = (in_div && Funct3[1]) ? a_neg : (a_neg ^ b_neg);
      dz_in  = in_div && op_b == '0;
      ovf_in = in_div && !Funct3[0] && op_a == MIN_V && op_b == {XLEN{1'b1}};
   end

`ifdef EARLY_OUT_EN
   logic early_in;
   assign early_in = in_div ? (dz_in || ovf_in) : (op_a == '0 || op_b == '0);
`endif

   logic [XLEN:0]     mul_sum, rem_sh;
   logic [XLEN-1:0]   rem_diff, q_c, r_c, fin_res;
   logic              ge;
   logic [2*XLEN-1:0] acc_nx, prod_c;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
      rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      ge       = rem_sh >= {1'b0, b_q};
      rem_diff = rem_sh[XLEN-1:0] - b_q;
      if (state_q == S_MUL)
         acc_nx = {mul_sum, acc_q[XLEN-1:1]};
      else
         acc_nx = {(ge ? rem_diff : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], ge};
      prod_c = neg_q ? -acc_nx : acc_nx;
      q_c    = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
      r_c    = neg_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
      if (state_q == S_MUL)
         fin_res = (f3_q == F3_MUL) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
      else if (dz_q || ovf_q)
         fin_res = spec_res(f3_q[1], dz_q, dvd_q);
      else
         fin_res = f3_q[1] ? r_c : q_c;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         f3_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         dvd_q       <= '0;
         acc_q       <= '0;
         neg_q       <= 1'b0;
         dz_q        <= 1'b0;
         ovf_q       <= 1'b0;
         md_valid_q  <= 1'b0;
         md_result_q <= '0;
      end else if (kill) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         md_valid_q <= 1'b0;
      end else begin
         md_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  f3_q    <= Funct3;
                  a_q     <= a_abs;
                  b_q     <= b_abs;
                  dvd_q   <= op_a;
                  neg_q   <= neg_in;
                  dz_q    <= dz_in;
                  ovf_q   <= ovf_in;
                  acc_q   <= {{XLEN{1'b0}}, (in_div ? a_abs : b_abs)};
                  cnt_q   <= CNT_W'(XLEN);
                  state_q <= in_div ? S_DIV : S_MUL;
`ifdef EARLY_OUT_EN
                  if (early_in) begin
                     state_q     <= S_DONE;
                     md_valid_q  <= 1'b1;
                     md_result_q <= in_div ? spec_res(Funct3[1], dz_in, op_a) : '0;
                  end
`endif
               end
            end
            S_MUL, S_DIV: begin
               acc_q <= acc_nx;
               cnt_q <= cnt_q - CNT_W'(1);
               // the final step's result is registered directly so md_valid lands in DONE
               if (cnt_q == CNT_W'(1)) begin
                  state_q     <= S_DONE;
                  md_valid_q  <= 1'b1;
                  md_result_q <= fin_res;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign md_stall  = state_q == S_MUL || state_q == S_DIV || accept;
   assign md_valid  = md_valid_q;
   assign md_result = md_result_q;

endmodule

// File: tb/tb_alu_controller_md.sv
// Directed bench for alu_controller_md: decode table, M-op table, kill/reset/back-to-back sequences.
import alu_md_pkg::*;

module tb_alu_controller_md;

   localparam int XLEN  = 32;
   localparam int LAT_N = XLEN + 1;
`ifdef EARLY_OUT_EN
   localparam int LAT_E = 1;
`else
   localparam int LAT_E = XLEN + 1;
`endif

   logic            clk = 1'b0;
   logic            reset, req_valid, kill, IsRType, Jalr;
   logic [1:0]      ALUOp;
   logic [6:0]      Funct7;
   logic [2:0]      Funct3;
   logic [XLEN-1:0] op_a, op_b, md_result;
   logic [3:0]      Operation;
   logic            md_stall, md_valid;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_controller_md #(.XLEN(XLEN), .OP_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .kill      (kill),
      .ALUOp     (ALUOp),
      .IsRType   (IsRType),
      .Funct7    (Funct7),
      .Funct3    (Funct3),
      .Jalr      (Jalr),
      .op_a      (op_a),
      .op_b      (op_b),
      .Operation (Operation),
      .md_stall  (md_stall),
      .md_valid  (md_valid),
      .md_result (md_result)
   );

   typedef struct {
      logic [1:0]  aluop;
      logic        isr;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic        jalr;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  exp_op;
      logic        is_m;
      int          lat;
      logic [31:0] exp_res;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t dv(input logic [1:0] aluop, input logic isr, input logic [6:0] f7,
                               input logic [2:0] f3, input logic jalr, input logic [3:0] eop);
      vec_t v;
      v.aluop = aluop; v.isr = isr; v.f7 = f7; v.f3 = f3; v.jalr = jalr;
      v.a = 32'h0000_1234; v.b = 32'h0000_0055; v.exp_op = eop;
      v.is_m = 1'b0; v.lat = 0; v.exp_res = '0;
      return v;
   endfunction

   function automatic vec_t mv(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input int lat, input logic [31:0] res);
      vec_t v;
      v.aluop = ALUOP_RI; v.isr = 1'b1; v.f7 = F7_MULDIV; v.f3 = f3; v.jalr = 1'b0;
      v.a = a; v.b = b; v.exp_op = OP_ADD; v.is_m = 1'b1; v.lat = lat; v.exp_res = res;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      req_valid = 1'b1; ALUOp = ALUOP_RI; IsRType = 1'b1; Funct7 = F7_MULDIV;
      Funct3 = f3; Jalr = 1'b0; op_a = a; op_b = b;
   endtask

   task automatic quiet_window(input string nm, input int n);
      int seen;
      seen = 0;
      repeat (n) begin
         @(posedge clk); #1;
         if (md_valid) seen++;
      end
      chk(nm, seen, 0);
   endtask

   // Present an M op from an IDLE cycle and hold it until md_valid, as a stalled pipeline would
   task automatic run_m(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int cyc, stalls;
      set_m(f3, a, b); #1;
      chk({nm, "_accept_stall"}, md_stall, 1);
      chk({nm, "_op"}, Operation, OP_ADD);
      stalls = 1; cyc = 0;
      while (cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (md_valid) break;
         if (md_stall) stalls++;
      end
      chk({nm, "_latency"}, cyc, exp_lat);
      chk({nm, "_stall_cycles"}, stalls, exp_lat);
      chk({nm, "_result"}, md_result, exp);
      chk({nm, "_done_stall"}, md_stall, 0);
      @(posedge clk); #1;
      req_valid = 1'b0; #1;
      chk({nm, "_pulse"}, md_valid, 0);
      chk({nm, "_idle_stall"}, md_stall, 0);
      chk({nm, "_hold"}, md_result, exp);
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; kill = 1'b0; ALUOp = '0; IsRType = 1'b0;
      Funct7 = '0; Funct3 = '0; Jalr = 1'b0; op_a = '0; op_b = '0;

      vt.push_back(dv(ALUOP_MEM, 1'b0, F7_BASE, 3'b010, 1'b0, OP_ADD));
      vt.push_back(dv(ALUOP_RI,  1'b1, F7_ALT,  3'b000, 1'b0, OP_SUB));
      vt.push_back(dv(ALUOP_RI,  1'b1, F7_BASE, 3'b000, 1'b0, OP_ADD));
      vt.push_back(dv(ALUOP_RI,  1'b0, F7_ALT,  3'b000, 1'b0, OP_ADD));
      vt.push_back(dv(ALUOP_RI,  1'b1, F7_ALT,  3'b101, 1'b0, OP_SRA));
      vt.push_back(dv(ALUOP_RI,  1'b1, F7_BASE, 3'b101, 1'b0, OP_SRL));
      vt.push_back(dv(ALUOP_RI,  1'b1, F7_BASE, 3'b001, 1'b0, OP_SLL));
      vt.push_back(dv(ALUOP_RI,  1'b1, F7_BASE, 3'b010, 1'b0, OP_SLT));
      vt.push_back(dv(ALUOP_RI,  1'b1, F7_BASE, 3'b011, 1'b0, OP_SLTU));
      vt.push_back(dv(ALUOP_RI,  1'b1, F7_BASE, 3'b100, 1'b0, OP_XOR));
      vt.push_back(dv(ALUOP_RI,  1'b1, F7_BASE, 3'b110, 1'b0, OP_OR));
      vt.push_back(dv(ALUOP_RI,  1'b1, F7_BASE, 3'b111, 1'b0, OP_AND));
      vt.push_back(dv(ALUOP_RI,  1'b0, F7_MULDIV, 3'b100, 1'b0, OP_XOR));
      vt.push_back(dv(ALUOP_RI,  1'b0, F7_BASE, 3'b000, 1'b1, OP_ADD));
      vt.push_back(dv(ALUOP_BR,  1'b0, F7_BASE, 3'b000, 1'b0, OP_BEQ));
      vt.push_back(dv(ALUOP_BR,  1'b0, F7_BASE, 3'b001, 1'b0, OP_BNE));
      vt.push_back(dv(ALUOP_BR,  1'b0, F7_BASE, 3'b100, 1'b0, OP_BLT));
      vt.push_back(dv(ALUOP_BR,  1'b0, F7_BASE, 3'b111, 1'b0, OP_BGEU));
      vt.push_back(dv(ALUOP_JL,  1'b0, F7_BASE, 3'b111, 1'b0, OP_ADD));

      vt.push_back(mv(F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, LAT_N, 32'hFFFF_FFEB));
      vt.push_back(mv(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_N, 32'hFFFF_FFFE));
      vt.push_back(mv(F3_MULH,   32'h8000_0000, 32'h8000_0000, LAT_N, 32'h4000_0000));
      vt.push_back(mv(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_N, 32'hFFFF_FFFF));
      vt.push_back(mv(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_N, 32'h0000_0000));
      vt.push_back(mv(F3_MUL,    32'h1234_5678, 32'h0000_0000, LAT_E, 32'h0000_0000));
      vt.push_back(mv(F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, LAT_N, 32'hFFFF_FFFD));
      vt.push_back(mv(F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, LAT_N, 32'hFFFF_FFFF));
      vt.push_back(mv(F3_DIVU,   32'hFFFF_FFF9, 32'h0000_0002, LAT_N, 32'h7FFF_FFFC));
      vt.push_back(mv(F3_REMU,   32'hFFFF_FFF9, 32'h0000_0002, LAT_N, 32'h0000_0001));
      vt.push_back(mv(F3_DIV,    32'h0000_0064, 32'hFFFF_FFF9, LAT_N, 32'hFFFF_FFF2));
      vt.push_back(mv(F3_REM,    32'h0000_0064, 32'hFFFF_FFF9, LAT_N, 32'h0000_0002));
      vt.push_back(mv(F3_DIVU,   32'h0000_0005, 32'h0000_0000, LAT_E, 32'hFFFF_FFFF));
      vt.push_back(mv(F3_DIV,    32'hFFFF_FFF8, 32'h0000_0000, LAT_E, 32'hFFFF_FFFF));
      vt.push_back(mv(F3_REMU,   32'h0000_000D, 32'h0000_0000, LAT_E, 32'h0000_000D));
      vt.push_back(mv(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, LAT_E, 32'h0000_0000));
      vt.push_back(mv(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, LAT_E, 32'h8000_0000));

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("reset_valid", md_valid, 0);
      chk("reset_result", md_result, 0);
      chk("reset_stall", md_stall, 0);

      foreach (vt[i]) begin
         if (!vt[i].is_m) begin
            req_valid = 1'b1; ALUOp = vt[i].aluop; IsRType = vt[i].isr; Funct7 = vt[i].f7;
            Funct3 = vt[i].f3; Jalr = vt[i].jalr; op_a = vt[i].a; op_b = vt[i].b;
            #1;
            chk($sformatf("dec%0d_op", i), Operation, vt[i].exp_op);
            chk($sformatf("dec%0d_stall", i), md_stall, 0);
            @(posedge clk); #1;
            chk($sformatf("dec%0d_valid", i), md_valid, 0);
         end else begin
            run_m($sformatf("m%0d", i), vt[i].f3, vt[i].a, vt[i].b, vt[i].exp_res, vt[i].lat);
         end
      end

      // kill ten cycles into a divide
      set_m(F3_DIV, 32'd100, 32'd7); #1;
      chk("kill_div_accept", md_stall, 1);
      repeat (10) @(posedge clk);
      #1 kill = 1'b1; req_valid = 1'b0;
      @(posedge clk); #1;
      kill = 1'b0; #1;
      chk("kill_stall", md_stall, 0);
      chk("kill_valid", md_valid, 0);
      quiet_window("kill_no_valid", 40);
      run_m("post_kill_mul", F3_MUL, 32'd6, 32'd9, 32'd54, LAT_N);

      // kill together with a new request blocks the accept
      set_m(F3_MUL, 32'd3, 32'd4);
      kill = 1'b1; #1;
      chk("kill_req_stall", md_stall, 0);
      @(posedge clk); #1;
      kill = 1'b0; req_valid = 1'b0; #1;
      chk("kill_req_idle", md_stall, 0);
      quiet_window("kill_req_no_valid", 36);
      chk("kill_req_result_held", md_result, 32'd54);

      // reset in the middle of a multiply
      set_m(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); #1;
      repeat (5) @(posedge clk);
      #1 reset = 1'b1; req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0; #1;
      chk("rst_mid_result", md_result, 0);
      chk("rst_mid_valid", md_valid, 0);
      chk("rst_mid_stall", md_stall, 0);
      quiet_window("rst_mid_no_valid", 36);

      // back-to-back: second op presented in the cycle right after the md_valid cycle
      run_m("b2b_first", F3_DIVU, 32'd1000, 32'd3, 32'd333, LAT_N);
      run_m("b2b_second", F3_REMU, 32'd1000, 32'd3, 32'd1, LAT_N);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_controller_md.md
Name: alu_controller_md

Overview:
- Parametrised successor to the single-cycle ALU controller.
- Keeps the combinational ALUOp/Funct3/Funct7/Jalr → Operation decode for base RV32I ops.
- Adds a sequential RV32M engine: an iterative shift-add multiplier and a restoring divider, with a stall handshake to the pipeline.
- Sits in the EX stage beside the ALU. The writeback mux selects md_result when md_valid is high.

Parameters:
- XLEN, 32, operand/result width; any even value ≥ 8.
- OP_W, 4, width of the ALU Operation code.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  EX-stage instruction valid this cycle
- kill  in  1  pipeline flush; aborts any M operation in flight
- ALUOp  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI
- IsRType  in  1  instruction opcode is OP (0110011)
- Funct7  in  7  instruction bits 31:25
- Funct3  in  3  instruction bits 14:12
- Jalr  in  1  JALR instruction
- op_a  in  XLEN  rs1 value
- op_b  in  XLEN  rs2 value
- Operation  out  OP_W  ALU operation, combinational, same encoding as the base controller
- md_stall  out  1  hold IF/ID/EX registers
- md_valid  out  1  md_result valid, one-cycle pulse
- md_result  out  XLEN  M-extension result

Behaviour:
- Clocking/reset: one clock domain (clk). Synchronous active-high reset → state IDLE, md_valid=0, md_result=0, counter=0; md_stall=0 in the following cycle.
- Operation decode: combinational, identical to the base decode for all non-M instructions. When an M instruction is decoded, Operation=ADD code (4'b0010) so the ALU stays benign.
- M instruction: req_valid & ALUOp==10 & IsRType & Funct7==7'b0000001. Funct3 selects:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - An M request latches op_a, op_b and Funct3, takes absolute values of signed operands, and records the result sign.
  - Next state MUL or DIV; counter=XLEN.
  - md_stall is asserted combinationally in the accept cycle.
- MUL: one shift-add step per cycle on a 2·XLEN product register. Counter decrements; at 1 → DONE.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). At counter 1 → DONE.
- DONE:
  - Apply sign correction (two's-complement negate).
  - Select the low or high product half, or quotient or remainder.
  - Register md_result, pulse md_valid=1, drop md_stall, return to IDLE.
- Latency: accept cycle t; md_valid at t+XLEN+1; md_stall high for cycles t..t+XLEN.
- Special cases (override in DONE, regardless of the iteration result):
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → dividend.
  - Signed overflow (op_a=MIN, op_b=−1): DIV → MIN; REM → 0.
- md_result holds its value until the next DONE or reset.
- req_valid while not IDLE is ignored; the stalled pipeline re-presents the same instruction, and no re-accept happens in the DONE cycle.
- kill in any state → IDLE next cycle, md_valid=0, md_stall=0 from the next cycle. kill has priority over DONE and over a new accept. If kill and an M request arrive together in IDLE, nothing is accepted.
- reset during MUL/DIV: same as kill, and md_result is also cleared.

Optional Feature:
- EARLY_OUT_EN.
- Defined: divide-by-zero, signed overflow, and multiply with either operand zero are detected in the accept cycle and go straight to DONE. Latency is 2 cycles (md_valid at t+1; md_stall high at t only).
- Undefined: these cases run the full XLEN iterations with identical final results.

Decomposition:
- Package alu_md_pkg:
  - typedef enum for ALU Operation codes (OP_W bits)
  - typedef enum for md state
  - Funct7 constants F7_BASE, F7_ALT, F7_MULDIV
  - Funct3 constants for the M operations
- Sub-module alu_op_decode: the purely combinational Operation decode, reused from the base controller logic.
- The sequential engine stays in the top module.

Test Plan:
- Base decode: ALUOp=10, Funct3=000, Funct7=0100000 → Operation=0011; md_stall=0, no md_valid.
- MUL: op_a=7, op_b=−3 → md_valid at t+33, md_result=0xFFFFFFEB; md_stall high exactly 33 cycles.
- MULHU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH: 0x80000000 × 0x80000000 → 0x40000000.
- DIV/REM: −7 by 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIVU by 0 → 0xFFFFFFFF. REM 0x80000000 by −1 → 0. With EARLY_OUT_EN, the by-zero and overflow cases give md_valid at t+1.
- kill asserted 10 cycles into a DIV → IDLE next cycle, md_stall=0, no md_valid. A new MUL accepted afterwards completes normally.
- reset asserted mid-MUL → md_result=0, md_valid=0. Back-to-back M ops: the second is accepted only after the md_valid cycle.
